// File: rtl/pdm_sample_feeder.sv
// PCM sample FIFO feeding a first-order sigma-delta modulator that builds PDM words for pdm_serializer.
// Optional feature: define PDM_FEEDER_HOLD_LAST_EN to repeat the last popped sample on underrun (default: midscale 0).
module pdm_sample_feeder #(
    parameter int PCM_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  enable,
    input  logic                  pcm_wr,
    input  logic [PCM_WIDTH-1:0]  pcm_data,
    input  logic                  ser_ready,
    input  logic                  flag_clr,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  overflow,
    output logic                  underrun
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MOD, S_WAIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [PCM_WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]     r_level;
    logic [PCM_WIDTH-1:0]    r_sample, r_acc;
    logic [DATA_WIDTH-1:0]   r_build, r_dout;
    logic [CW-1:0]           r_cnt;
    logic                    r_valid, r_ovf, r_udr, r_ser_d;

    logic                    w_full, w_empty, w_pop, w_push, w_last, w_fall;
    logic [PCM_WIDTH-1:0]    w_u, w_fallback;
    logic [PCM_WIDTH:0]      w_sum;
    logic [DATA_WIDTH-1:0]   w_build_nxt;

    assign w_full  = (r_level == (ADDR_WIDTH+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = enable && (r_state == S_FETCH) && !w_empty;
    assign w_push  = pcm_wr && (!w_full || w_pop);
    assign w_last  = (r_cnt == CW'(DATA_WIDTH-1));
    assign w_fall  = r_ser_d && !ser_ready;

`ifdef PDM_FEEDER_HOLD_LAST_EN
    // r_sample only ever holds the last popped value (or 0 after reset) when falling back
    assign w_fallback = r_sample;
`else
    assign w_fallback = '0;
`endif

    // Adding 2**(PCM_WIDTH-1) to a two's-complement value is an MSB flip
    assign w_u         = {~r_sample[PCM_WIDTH-1], r_sample[PCM_WIDTH-2:0]};
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_u};
    assign w_build_nxt = {r_build[DATA_WIDTH-2:0], w_sum[PCM_WIDTH]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FETCH;
                S_FETCH: w_state_nxt = S_MOD;
                S_MOD:   if (w_last) w_state_nxt = S_WAIT;
                S_WAIT:  if (w_fall) w_state_nxt = S_FETCH;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wptr] <= pcm_data;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_udr   <= 1'b0;
            r_ser_d <= 1'b0;
        end else begin
            r_ser_d <= ser_ready;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            // set beats clear when both land in the same cycle
            if (pcm_wr && w_full && !w_pop)                    r_ovf <= 1'b1;
            else if (flag_clr)                                 r_ovf <= 1'b0;
            if (enable && (r_state == S_FETCH) && w_empty)     r_udr <= 1'b1;
            else if (flag_clr)                                 r_udr <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sample <= '0;
            r_acc    <= '0;
            r_build  <= '0;
            r_dout   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else if (!enable) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_sample <= w_empty ? w_fallback : r_mem[r_rptr];
                    r_cnt    <= '0;
                end
                S_MOD: begin
                    r_acc   <= w_sum[PCM_WIDTH-1:0];
                    r_build <= w_build_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_dout  <= w_build_nxt;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_valid = r_valid;
    assign Data_out   = r_dout;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;
    assign underrun   = r_udr;

endmodule
